// File: rtl/jtcontra_main_io_if.sv
// jtcontra_main_io_if
// Bundles the main-CPU bus and the sound-CPU handshake of jtcontra_main_io.
//   master : CPU decoder / sound side, drives bus writes and snd_ack
//   slave  : jtcontra_main_io, drives rom_addr and the sound latch/status
// Signals:
//   cpu_cen, cpu_addr[15:0], cpu_dout[7:0], bank_we, out_we  -> slave
//   rom_addr[BANK_W+12:0]                                    <- slave
//   snd_latch[7:0], snd_irq, snd_status[7:0]                 <- slave
//   snd_ack                                                  -> slave
interface jtcontra_main_io_if #(
    parameter int BANK_W = 4
) ();
    logic                cpu_cen;
    logic [15:0]         cpu_addr;
    logic [7:0]          cpu_dout;
    logic                bank_we;
    logic                out_we;
    logic [BANK_W+12:0]  rom_addr;
    logic [7:0]          snd_latch;
    logic                snd_irq;
    logic                snd_ack;
    logic [7:0]          snd_status;

    modport master (
        output cpu_cen, cpu_addr, cpu_dout, bank_we, out_we, snd_ack,
        input  rom_addr, snd_latch, snd_irq, snd_status
    );

    modport slave (
        input  cpu_cen, cpu_addr, cpu_dout, bank_we, out_we, snd_ack,
        output rom_addr, snd_latch, snd_irq, snd_status
    );
endinterface

// File: rtl/jtcontra_main_io.sv
// jtcontra_main_io
// Main-CPU I/O controller: ROM bank register, sound-command FIFO with an
// IRQ/ack handshake toward the sound CPU, video IRQ latch, coin-counter
// pulse stretchers and watchdog.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : CPU bus + sound handshake (jtcontra_main_io_if.slave)
//   gfx_irqn   : video IRQ, active low, asynchronous to the CPU
//   irq_ack    : CPU IRQ acknowledge pulse
//   irq_n      : main CPU IRQ, active low
//   coin_cnt   : coin-counter drives
//   wdog_rst   : one-clk watchdog reset pulse
module jtcontra_main_io #(
    parameter int BANK_W   = 4,
    parameter int BANK_OFS = 4,
    parameter int FIFO_AW  = 2,
    parameter int WDOG_W   = 16,
    parameter int WDOG_EN  = 1,
    parameter int COIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jtcontra_main_io_if.slave    bus,
    input  logic                 gfx_irqn,
    input  logic                 irq_ack,
    output logic                 irq_n,
    output logic [1:0]           coin_cnt,
    output logic                 wdog_rst
);
    localparam int AW    = BANK_W + 13;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(COIN_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} snd_state_t;

    logic [BANK_W-1:0]  bank, bank_sum;
    logic [7:0]         staging;
    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count, count_nx;
    logic               overflow, full, empty;
    logic [3:0]         count_sat;
    snd_state_t         st;
    logic [7:0]         latch_r;
    logic               irq_r;
    logic               gfx_s, gfx_l, gfx_fall;
    logic [WDOG_W-1:0]  wdog_cnt;
    logic [CW-1:0]      coin_left [2];

    logic out_wr, wr_coin, wr_push, wr_stage, wr_kick, pop, push_ok;

    assign out_wr   = bus.cpu_cen & bus.out_we;
    assign wr_coin  = out_wr & (bus.cpu_addr[2:1] == 2'b00);
    assign wr_push  = out_wr & (bus.cpu_addr[2:1] == 2'b01);
    assign wr_stage = out_wr & (bus.cpu_addr[2:1] == 2'b10);
    assign wr_kick  = out_wr & (bus.cpu_addr[2:1] == 2'b11);

    // ROM banking
    assign bank_sum     = bank + BANK_W'(BANK_OFS);
    assign bus.rom_addr = bus.cpu_addr[15] ? AW'({1'b0, bus.cpu_addr[14:0]})
                                           : AW'({bank_sum, bus.cpu_addr[12:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            bank    <= '0;
            staging <= '0;
        end else begin
            if (bus.cpu_cen && bus.bank_we) bank <= bus.cpu_dout[BANK_W-1:0];
            if (wr_stage) staging <= bus.cpu_dout;
        end
    end

    // Sound FIFO. A push into a full FIFO still lands when the same clock
    // pops, since the pop frees the slot being written.
    assign full    = (count == (FIFO_AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = (st == S_PRESENT) & bus.snd_ack;
    assign push_ok = wr_push & (~full | pop);

    always_comb begin
        count_nx = count;
        case ({push_ok, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
        count_sat = (32'(count) > 15) ? 4'hF : 4'(count);
    end

    assign bus.snd_status = {overflow, full, empty, 1'b0, count_sat};

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= staging;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
            if (wr_push && full && !pop) overflow <= 1'b1;
        end
    end

    // The latch loads whenever PRESENT is entered, so it never changes
    // while snd_irq is high; reading at the GAP exit also picks up a byte
    // written on the same clock as the previous pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            latch_r <= '0;
            irq_r   <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (!empty) begin
                    st      <= S_PRESENT;
                    irq_r   <= 1'b1;
                    latch_r <= fifo_mem[rd_ptr];
                end
                S_PRESENT: if (bus.snd_ack) begin
                    irq_r <= 1'b0;
                    st    <= (count_nx != '0) ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    st      <= S_PRESENT;
                    irq_r   <= 1'b1;
                    latch_r <= fifo_mem[rd_ptr];
                end
                default: begin
                    st    <= S_IDLE;
                    irq_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snd_latch = latch_r;
    assign bus.snd_irq   = irq_r;

    // Video IRQ: two-stage sample, edge detected between the stages.
    assign gfx_fall = gfx_l & ~gfx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            gfx_s <= 1'b1;
            gfx_l <= 1'b1;
            irq_n <= 1'b1;
        end else begin
            gfx_s <= gfx_irqn;
            gfx_l <= gfx_s;
            irq_n <= ~(gfx_fall | (~irq_n & ~irq_ack));
        end
    end

    // Watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_rst <= 1'b0;
        end else begin
            wdog_rst <= 1'b0;
            if (bus.cpu_cen) begin
                if (wr_kick) begin
                    wdog_cnt <= '0;
                end else if (&wdog_cnt) begin
                    wdog_cnt <= '0;
                    wdog_rst <= (WDOG_EN != 0);
                end else begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
            end
        end
    end

    // Coin counters: a write reloads the full length even mid-pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_left[0] <= '0;
            coin_left[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_coin && bus.cpu_dout[i])
                    coin_left[i] <= CW'(COIN_LEN);
                else if (bus.cpu_cen && coin_left[i] != '0)
                    coin_left[i] <= coin_left[i] - 1'b1;
            end
        end
    end

    assign coin_cnt = {coin_left[1] != '0, coin_left[0] != '0};
endmodule

// File: tb/tb_jtcontra_main_io.sv
module tb_jtcontra_main_io;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gfx_irqn = 1'b1;
    logic       irq_ack = 1'b0;
    logic       irq_n;
    logic [1:0] coin_cnt;
    logic       wdog_rst;
    int         total = 0;
    int         bad = 0;

    jtcontra_main_io_if #(.BANK_W(4)) bus ();

    jtcontra_main_io #(
        .BANK_W(4), .BANK_OFS(4), .FIFO_AW(2),
        .WDOG_W(4), .WDOG_EN(1), .COIN_LEN(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gfx_irqn (gfx_irqn),
        .irq_ack  (irq_ack),
        .irq_n    (irq_n),
        .coin_cnt (coin_cnt),
        .wdog_rst (wdog_rst)
    );

    always #5 clk = ~clk;

    // Helpers start at a negedge, drive, and return at the following negedge.
    task automatic idle_inputs();
        bus.cpu_cen  = 1'b0;
        bus.bank_we  = 1'b0;
        bus.out_we   = 1'b0;
        bus.snd_ack  = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_dout = 8'h00;
        irq_ack      = 1'b0;
        gfx_irqn     = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cpu_wr(input logic is_bank, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_cen  = 1'b1;
        bus.bank_we  = is_bank;
        bus.out_we   = ~is_bank;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        @(negedge clk);
        bus.cpu_cen = 1'b0;
        bus.bank_we = 1'b0;
        bus.out_we  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cpu_wr(1'b0, 16'h001C, d);
        cpu_wr(1'b0, 16'h001A, 8'h00);
    endtask

    task automatic do_ack();
        bus.snd_ack = 1'b1;
        @(negedge clk);
        bus.snd_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.cpu_addr = 16'h0000;
        #1;
        total++; if (bus.snd_latch !== 8'h00) begin bad++; $display("FAIL rst_latch got=%h exp=%h", bus.snd_latch, 8'h00); end
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL rst_snd_irq got=%b exp=0", bus.snd_irq); end
        total++; if (bus.snd_status !== 8'h20) begin bad++; $display("FAIL rst_status got=%h exp=%h", bus.snd_status, 8'h20); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL rst_irq_n got=%b exp=1", irq_n); end
        total++; if (coin_cnt !== 2'b00) begin bad++; $display("FAIL rst_coin got=%b exp=00", coin_cnt); end
        total++; if (wdog_rst !== 1'b0) begin bad++; $display("FAIL rst_wdog got=%b exp=0", wdog_rst); end
        total++; if (bus.rom_addr !== 17'h08000) begin bad++; $display("FAIL rst_rom_addr got=%h exp=%h", bus.rom_addr, 17'h08000); end
        @(negedge clk);
        // reset in the middle of a handshake with an IRQ pending and a coin pulse active
        push(8'h55);
        cpu_wr(1'b0, 16'h0018, 8'h03);
        gfx_irqn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.snd_irq !== 1'b1) begin bad++; $display("FAIL pre_rst_snd_irq got=%b exp=1", bus.snd_irq); end
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL pre_rst_irq_n got=%b exp=0", irq_n); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL midrst_snd_irq got=%b exp=0", bus.snd_irq); end
        total++; if (bus.snd_latch !== 8'h00) begin bad++; $display("FAIL midrst_latch got=%h exp=00", bus.snd_latch); end
        total++; if (bus.snd_status !== 8'h20) begin bad++; $display("FAIL midrst_status got=%h exp=20", bus.snd_status); end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL midrst_irq_n got=%b exp=1", irq_n); end
        total++; if (coin_cnt !== 2'b00) begin bad++; $display("FAIL midrst_coin got=%b exp=00", coin_cnt); end
        do_reset();
    endtask

    task automatic test_bank();
        do_reset();
        cpu_wr(1'b1, 16'h0000, 8'h0B);
        bus.cpu_addr = 16'h6123;
        #1;
        total++; if (bus.rom_addr !== 17'h1E123) begin bad++; $display("FAIL bank_lo got=%h exp=%h", bus.rom_addr, 17'h1E123); end
        bus.cpu_addr = 16'h8123;
        #1;
        total++; if (bus.rom_addr !== 17'h00123) begin bad++; $display("FAIL bank_hi got=%h exp=%h", bus.rom_addr, 17'h00123); end
        @(negedge clk);
        // bank_we without cpu_cen must be ignored
        bus.bank_we  = 1'b1;
        bus.cpu_dout = 8'h02;
        bus.cpu_addr = 16'h6123;
        @(negedge clk);
        bus.bank_we = 1'b0;
        total++; if (bus.rom_addr !== 17'h1E123) begin bad++; $display("FAIL bank_nocen got=%h exp=%h", bus.rom_addr, 17'h1E123); end
        // bank + offset wraps within the bank width: 0xE + 4 -> 0x2
        cpu_wr(1'b1, 16'h6123, 8'h0E);
        total++; if (bus.rom_addr !== 17'h04123) begin bad++; $display("FAIL bank_wrap got=%h exp=%h", bus.rom_addr, 17'h04123); end
        // upper data bits ignored
        cpu_wr(1'b1, 16'h6123, 8'hFB);
        total++; if (bus.rom_addr !== 17'h1E123) begin bad++; $display("FAIL bank_trunc got=%h exp=%h", bus.rom_addr, 17'h1E123); end
    endtask

    task automatic test_fifo_handshake();
        logic [7:0] exp_seq [2];
        exp_seq[0] = 8'h11;
        exp_seq[1] = 8'h12;
        do_reset();
        push(8'h10);
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL hs_irq_latency got=%b exp=0", bus.snd_irq); end
        total++; if (bus.snd_status !== 8'h01) begin bad++; $display("FAIL hs_status1 got=%h exp=01", bus.snd_status); end
        @(negedge clk);
        total++; if (bus.snd_irq !== 1'b1) begin bad++; $display("FAIL hs_irq_rise got=%b exp=1", bus.snd_irq); end
        total++; if (bus.snd_latch !== 8'h10) begin bad++; $display("FAIL hs_latch0 got=%h exp=10", bus.snd_latch); end
        push(8'h11);
        push(8'h12);
        total++; if (bus.snd_status !== 8'h03) begin bad++; $display("FAIL hs_status3 got=%h exp=03", bus.snd_status); end
        total++; if (bus.snd_latch !== 8'h10) begin bad++; $display("FAIL hs_latch_stable got=%h exp=10", bus.snd_latch); end
        for (int i = 0; i < 2; i++) begin
            do_ack();
            total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL hs_gap%0d got=%b exp=0", i, bus.snd_irq); end
            @(negedge clk);
            total++; if (bus.snd_irq !== 1'b1) begin bad++; $display("FAIL hs_present%0d got=%b exp=1", i, bus.snd_irq); end
            total++; if (bus.snd_latch !== exp_seq[i]) begin bad++; $display("FAIL hs_latch%0d got=%h exp=%h", i + 1, bus.snd_latch, exp_seq[i]); end
        end
        do_ack();
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL hs_idle_irq got=%b exp=0", bus.snd_irq); end
        total++; if (bus.snd_status !== 8'h20) begin bad++; $display("FAIL hs_empty got=%h exp=20", bus.snd_status); end
        do_ack();
        @(negedge clk);
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL hs_idle_ack got=%b exp=0", bus.snd_irq); end
        total++; if (bus.snd_status !== 8'h20) begin bad++; $display("FAIL hs_idle_status got=%h exp=20", bus.snd_status); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hA2;
        exp_seq[1] = 8'hA3;
        exp_seq[2] = 8'hB0;
        do_reset();
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        total++; if (bus.snd_status !== 8'h44) begin bad++; $display("FAIL ov_full got=%h exp=44", bus.snd_status); end
        total++; if (bus.snd_latch !== 8'hA0) begin bad++; $display("FAIL ov_head got=%h exp=A0", bus.snd_latch); end
        cpu_wr(1'b0, 16'h001C, 8'hB0);
        // push and ack on the same clock while full
        bus.cpu_cen  = 1'b1;
        bus.out_we   = 1'b1;
        bus.cpu_addr = 16'h001A;
        bus.snd_ack  = 1'b1;
        @(negedge clk);
        bus.cpu_cen = 1'b0;
        bus.out_we  = 1'b0;
        bus.snd_ack = 1'b0;
        total++; if (bus.snd_status !== 8'h44) begin bad++; $display("FAIL ov_pushpop got=%h exp=44", bus.snd_status); end
        total++; if (bus.snd_irq !== 1'b0) begin bad++; $display("FAIL ov_gap got=%b exp=0", bus.snd_irq); end
        cpu_wr(1'b0, 16'h001C, 8'hC0);
        cpu_wr(1'b0, 16'h001A, 8'h00);
        total++; if (bus.snd_status !== 8'hC4) begin bad++; $display("FAIL ov_sticky got=%h exp=C4", bus.snd_status); end
        total++; if (bus.snd_latch !== 8'hA1) begin bad++; $display("FAIL ov_next got=%h exp=A1", bus.snd_latch); end
        for (int i = 0; i < 3; i++) begin
            do_ack();
            @(negedge clk);
            total++; if (bus.snd_latch !== exp_seq[i]) begin bad++; $display("FAIL ov_drain%0d got=%h exp=%h", i, bus.snd_latch, exp_seq[i]); end
        end
        do_ack();
        total++; if (bus.snd_status !== 8'hA0) begin bad++; $display("FAIL ov_drained got=%h exp=A0", bus.snd_status); end
    endtask

    task automatic test_irq();
        do_reset();
        gfx_irqn = 1'b0;
        @(negedge clk);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_1clk got=%b exp=1", irq_n); end
        @(negedge clk);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_2clk got=%b exp=0", irq_n); end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_ack got=%b exp=1", irq_n); end
        @(negedge clk);
        @(negedge clk);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_level_no_retrig got=%b exp=1", irq_n); end
        gfx_irqn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        gfx_irqn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_second got=%b exp=0", irq_n); end
        gfx_irqn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        gfx_irqn = 1'b0;
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_set_wins got=%b exp=0", irq_n); end
        @(negedge clk);
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_hold got=%b exp=0", irq_n); end
    endtask

    task automatic test_watchdog();
        int pulses;
        do_reset();
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            bus.cpu_cen = 1'b1;
            @(negedge clk);
            bus.cpu_cen = 1'b0;
            if (wdog_rst === 1'b1) pulses++;
            total++; if (wdog_rst !== ((t % 16) == 0)) begin bad++; $display("FAIL wdog_free t=%0d got=%b exp=%b", t, wdog_rst, (t % 16) == 0); end
            @(negedge clk);
            total++; if (wdog_rst !== 1'b0) begin bad++; $display("FAIL wdog_width t=%0d got=%b exp=0", t, wdog_rst); end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL wdog_free_count got=%0d exp=2", pulses); end

        do_reset();
        pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            bus.cpu_cen = 1'b1;
            if (t % 10 == 0) begin
                bus.out_we   = 1'b1;
                bus.cpu_addr = 16'h001E;
            end
            @(negedge clk);
            bus.cpu_cen = 1'b0;
            bus.out_we  = 1'b0;
            if (wdog_rst === 1'b1) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL wdog_kicked got=%0d exp=0", pulses); end

        do_reset();
        for (int t = 1; t <= 32; t++) begin
            bus.cpu_cen = 1'b1;
            if (t == 16) begin
                bus.out_we   = 1'b1;
                bus.cpu_addr = 16'h001E;
            end
            @(negedge clk);
            bus.cpu_cen = 1'b0;
            bus.out_we  = 1'b0;
            total++; if (wdog_rst !== (t == 32)) begin bad++; $display("FAIL wdog_terminal_kick t=%0d got=%b exp=%b", t, wdog_rst, t == 32); end
            @(negedge clk);
        end
    endtask

    task automatic test_coin();
        logic [1:0] exp;
        do_reset();
        cpu_wr(1'b0, 16'h0018, 8'h01);
        total++; if (coin_cnt !== 2'b01) begin bad++; $display("FAIL coin_start got=%b exp=01", coin_cnt); end
        for (int t = 1; t <= 10; t++) begin
            exp = (t < 8) ? 2'b01 : 2'b00;
            bus.cpu_cen = 1'b1;
            @(negedge clk);
            bus.cpu_cen = 1'b0;
            total++; if (coin_cnt !== exp) begin bad++; $display("FAIL coin_len t=%0d got=%b exp=%b", t, coin_cnt, exp); end
            @(negedge clk);
            total++; if (coin_cnt !== exp) begin bad++; $display("FAIL coin_nocen t=%0d got=%b exp=%b", t, coin_cnt, exp); end
        end

        do_reset();
        cpu_wr(1'b0, 16'h0018, 8'h01);
        for (int t = 1; t <= 15; t++) begin
            exp = {(t >= 5) && (t < 13), t < 13};
            bus.cpu_cen = 1'b1;
            if (t == 5) begin
                bus.out_we   = 1'b1;
                bus.cpu_addr = 16'h0018;
                bus.cpu_dout = 8'h03;
            end
            @(negedge clk);
            bus.cpu_cen = 1'b0;
            bus.out_we  = 1'b0;
            total++; if (coin_cnt !== exp) begin bad++; $display("FAIL coin_retrig t=%0d got=%b exp=%b", t, coin_cnt, exp); end
            @(negedge clk);
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        do_reset();
        test_reset();
        test_bank();
        test_fifo_handshake();
        test_overflow();
        test_irq();
        test_watchdog();
        test_coin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
